// File: rtl/cpu_pkg.sv
// Shared core definitions: redirect FSM states, branch funct3 encodings, ALU flag bit positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } redir_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flags are {v,c,n,z} computed from rs1-rs2.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/branch_unit.sv
// Branch condition evaluation from ALU flags; taken only when Branch is asserted.
module branch_unit
  import cpu_pkg::*;
(
  input  logic       Branch,
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = flags[FLAG_Z];
      F3_BNE:  cond = ~flags[FLAG_Z];
      F3_BLT:  cond = flags[FLAG_N] ^ flags[FLAG_V];
      F3_BGE:  cond = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      // Unsigned compare: carry set means no borrow, i.e. rs1 >= rs2.
      F3_BLTU: cond = ~flags[FLAG_C];
      F3_BGEU: cond = flags[FLAG_C];
      default: cond = 1'b0;
    endcase
  end

  assign taken = Branch & cond;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect sequencer: redirect handshake to fetch, EX stall, IF/ID squash.
// Optional performance counters built when BRANCH_REDIRECT_PERF_EN is defined.
module branch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [2:0]        ex_funct3,
  input  logic [3:0]        ex_flags,
  input  logic [XLEN-1:0]   ex_target,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready,
  output logic              stall_ex,
  output logic              flush_ifid,
  output logic              misalign_exc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_taken,
  output logic [PERF_W-1:0] perf_stall
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  redir_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic stall_q, stall_d;
  logic flush_q, flush_d;
  logic mis_q, mis_d;

  logic taken_cond;
  logic redirect_req;
  logic aligned;

  branch_unit u_branch_unit (
    .Branch (ex_branch),
    .funct3 (ex_funct3),
    .flags  (ex_flags),
    .taken  (taken_cond)
  );

  assign redirect_req = ex_valid & (ex_jump | taken_cond);
  assign aligned      = (ex_target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_req) begin
          if (aligned) begin
            pc_d    = ex_target;
            state_d = REDIRECT;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    valid_d = (state_d == REDIRECT);
    stall_d = (state_d == REDIRECT);
    flush_d = (state_d == REDIRECT) || (state_d == FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign redirect_valid = valid_q;
  assign redirect_pc    = pc_q;
  assign stall_ex       = stall_q;
  assign flush_ifid     = flush_q;
  assign misalign_exc   = mis_q;

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
  logic [PERF_W-1:0] perf_taken_q, perf_taken_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    perf_stall_d    = perf_stall_q;
    if ((state_q == IDLE) && ex_valid && ex_branch && (perf_branches_q != '1))
      perf_branches_d = perf_branches_q + 1'b1;
    if ((state_q == IDLE) && (state_d == REDIRECT) && (perf_taken_q != '1))
      perf_taken_d = perf_taken_q + 1'b1;
    if ((state_q == REDIRECT) && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_taken    = perf_taken_q;
  assign perf_stall    = perf_stall_q;
`else
  assign perf_branches = '0;
  assign perf_taken    = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow redirects in the pipelined 32-bit core. It sits in EX: it evaluates the branch condition from ALU flags, or takes an unconditional jump. It then drives a valid/ready redirect handshake to fetch, stalls EX until fetch accepts, and squashes wrong-path IF/ID instructions for a fixed number of cycles. Fetch predicts not-taken, so every taken branch or jump redirects.

Parameters:
XLEN, 32, address width
FLUSH_CYCLES, 2, cycles of IF/ID squash after redirect acceptance; legal range 1..15
PERF_W, 32, width of performance counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  valid instruction in EX
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is JAL/JALR (unconditional)
ex_funct3  in  3  branch funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
ex_flags  in  4  ALU flags {v,c,n,z} from rs1-rs2
ex_target  in  XLEN  computed branch/jump target
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  new fetch PC, stable while redirect_valid
redirect_ready  in  1  fetch accepts redirect
stall_ex  out  1  hold EX/MEM advance
flush_ifid  out  1  squash IF and ID stage contents
misalign_exc  out  1  one-cycle pulse: taken target not word aligned
perf_branches  out  PERF_W  conditional branches retired through EX
perf_taken  out  PERF_W  redirects issued
perf_stall  out  PERF_W  cycles spent in REDIRECT

Behaviour:
- Reset (async): state IDLE; redirect_valid=0; redirect_pc=0; stall_ex=0; flush_ifid=0; misalign_exc=0; flush counter=0; perf counters=0.
- Condition: taken_cond = ex_branch & cond(funct3,flags).
  - beq: z. bne: ~z.
  - blt: n^v. bge: ~(n^v).
  - bltu: ~c. bgeu: c.
  - funct3 01x gives not-taken.
- redirect_req = ex_valid & (ex_jump | taken_cond), evaluated only in IDLE.
- IDLE:
  - If redirect_req and ex_target[1:0]==00: latch redirect_pc<=ex_target, go to REDIRECT.
  - If redirect_req and ex_target[1:0]!=00: pulse misalign_exc for the next cycle only, no redirect, stay IDLE.
  - Not-taken branch: no action; zero-cycle penalty.
- REDIRECT:
  - redirect_valid=1, stall_ex=1, flush_ifid=1.
  - redirect_pc holds until redirect_ready is seen high.
  - On redirect_valid&redirect_ready: go to FLUSH, counter<=FLUSH_CYCLES-1.
- FLUSH:
  - flush_ifid=1, redirect_valid=0, stall_ex=0.
  - Counter decrements each cycle; at 0 go to IDLE.
  - FLUSH_CYCLES=1 gives exactly one FLUSH cycle.
- Redirect latency: the request cycle is registered, so redirect_valid rises 1 cycle after redirect_req.
- ex_valid/ex_branch/ex_jump are ignored outside IDLE. Those instructions are wrong-path or the held branch.
- redirect_ready is only sampled in REDIRECT; a high value in IDLE/FLUSH has no effect.
- Back-to-back: a taken branch arriving the first cycle back in IDLE is accepted normally.
- Reset mid-REDIRECT or mid-FLUSH: redirect dropped immediately, all outputs at reset values.
- All outputs are registered except perf counters, which are read directly from their registers.

Optional Feature:
BRANCH_REDIRECT_PERF_EN.
- Defined:
  - perf_branches increments on each IDLE cycle with ex_valid&ex_branch.
  - perf_taken increments on each IDLE→REDIRECT transition.
  - perf_stall increments each REDIRECT cycle.
  - All three saturate at all-ones.
- Undefined: counters are not built; perf_* ports remain and are tied to 0.

Decomposition:
- Shared package (cpu_pkg): state enum {IDLE, REDIRECT, FLUSH}; funct3 branch encodings; flag bit index constants V=3, C=2, N=1, Z=0.
- One sub-module: the existing branch_unit is instantiated for condition evaluation, with Branch=ex_branch. No other sub-modules.

Test Plan:
- beq, flags z=1, target 0x100, ready held high → redirect_valid 1 cycle later with pc 0x100; stall_ex 1 cycle; flush_ifid high 1+2 cycles; back to IDLE.
- blt, flags n=0 v=1, ready low 3 cycles → redirect_valid and redirect_pc=target stable 4 cycles; stall_ex 4 cycles; perf_stall=4 (macro on).
- bgeu, c=0 → no redirect, no flush, zero stall; bltu, c=0 → redirect.
- jal, target 0x102 → misalign_exc pulses 1 cycle; redirect_valid stays 0; state IDLE.
- reset asserted mid-REDIRECT → outputs 0 immediately; after release a ready pulse causes no redirect.
- ex_valid taken branch during FLUSH → ignored; taken branch in first IDLE cycle → accepted; perf_taken=2.
